// File: rtl/register_bank_pkg.sv
// Shared types and helpers for the multi-port register bank.
// Default geometry matches the 32x64 ARM integer file.
package register_bank_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ZERO_IDX = 31;

  // Address width for n entries (n need not be a power of two).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/register_bank_init_seq.sv
// Init sequencer: walks every register once after reset or clear.
// Holds the bank off the write-back path until the walk finishes.
module register_bank_init_seq
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int INIT_IDX = 1,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [WIDTH-1:0] init_data,
  output logic             ready
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state, state_n;
  logic [AW-1:0] idx, idx_n;

  // State and walk index; reset restarts the walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next state: walk to LAST then run; clear restarts the walk.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    init_we = 1'b0;
    ready   = 1'b0;
    unique case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (idx == LAST) begin
          state_n = ST_RUN;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        if (clear) begin
          state_n = ST_INIT;
          idx_n   = '0;
        end
      end
    endcase
  end

  assign init_addr = idx;
  assign init_data = (INIT_IDX != 0) ? WIDTH'(idx) : '0;

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register bank between decode and write-back.
// N combinational read ports, one write port, optional XZR/bypass.
module register_bank_mp
  import register_bank_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_EN  = 1,
  parameter  int ZERO_IDX = DEF_ZERO_IDX,
  parameter  int BYPASS   = 1,
  parameter  int INIT_IDX = 1,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    clear,
  output logic                    ready
);

  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] ZIDX    = AW'(ZERO_IDX);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;
  logic             user_we;

  register_bank_init_seq #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .INIT_IDX(INIT_IDX),
    .AW      (AW)
  ) u_init (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .ready    (ready)
  );

  assign user_we = wr_en && ready && !clear
                && ({1'b0, wr_addr} < DEPTH_W)
                && !((ZERO_EN != 0) && (wr_addr == ZIDX));

  // Storage: sequencer owns the array during INIT, write-back otherwise.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (user_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;

    assign a = rd_addr[k*AW +: AW];

    // Read mux: range, zero register, bypass, then array.
    always_comb begin
      d = '0;
      if (!ready || ({1'b0, a} >= DEPTH_W)) begin
        d = '0;
      end else if ((ZERO_EN != 0) && (a == ZIDX)) begin
        d = '0;
      end else if ((BYPASS != 0) && wr_en && (a == wr_addr)) begin
        d = wr_data;
      end else begin
        d = mem[a];
      end
    end

    assign rd_data[k*WIDTH +: WIDTH] = d;
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench for register_bank_mp: default, no-bypass
// and 20-entry/3-port instances share one stimulus stream.
module tb_register_bank_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  ra;
  logic [14:0] ras;

  logic [127:0] rd;
  logic [127:0] rd_nb;
  logic [191:0] rd_s;
  logic         ready;
  logic         ready_nb;
  logic         ready_s;

  int errors = 0;
  int checks = 0;
  int n;
  int ns;

  always #5 clk = ~clk;

  register_bank_mp dut (
    .clk(clk), .rst(rst), .rd_addr(ra), .rd_data(rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .ready(ready)
  );

  register_bank_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(ra), .rd_data(rd_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .ready(ready_nb)
  );

  register_bank_mp #(.DEPTH(20), .NUM_RD(3)) dut_s (
    .clk(clk), .rst(rst), .rd_addr(ras), .rd_data(rd_s),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .ready(ready_s)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the main instance is ready (bounded).
  task automatic wait_ready(output int cnt, output int cnt_s);
    cnt   = 0;
    cnt_s = -1;
    while (!ready && cnt < 200) begin
      step();
      cnt++;
      if (ready_s && cnt_s < 0) cnt_s = cnt;
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; ra = '0; ras = '0;
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rd0", rd[63:0], 64'd0);
    step();
    rst = 1'b0;
    wait_ready(n, ns);
    chk("init_len", 64'(n), 64'd32);
    chk("init_len_s", 64'(ns), 64'd20);

    // Initial contents
    ra = {5'd30, 5'd5};
    #1;
    chk("init_r5", rd[63:0], 64'd5);
    chk("init_r30", rd[127:64], 64'd30);
    ra = {5'd30, 5'd31};
    #1;
    chk("init_xzr", rd[63:0], 64'd0);

    // Plain write, then XZR write
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEAD_BEEF;
    step();
    wr_en = 1'b0; ra = {5'd0, 5'd7};
    #1;
    chk("wr_r7", rd[63:0], 64'hDEAD_BEEF);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234; ra = {5'd0, 5'd31};
    #1;
    chk("xzr_same", rd[63:0], 64'd0);
    step();
    wr_en = 1'b0;
    #1;
    chk("xzr_after", rd[63:0], 64'd0);

    // Bypass versus no bypass
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hAA; ra = {5'd9, 5'd9};
    #1;
    chk("byp_p0", rd[63:0], 64'hAA);
    chk("byp_p1", rd[127:64], 64'hAA);
    chk("nobyp_p0", rd_nb[63:0], 64'd9);
    chk("nobyp_p1", rd_nb[127:64], 64'd9);
    step();
    wr_en = 1'b0;
    #1;
    chk("nobyp_next0", rd_nb[63:0], 64'hAA);
    chk("nobyp_next1", rd_nb[127:64], 64'hAA);

    // Small bank: out-of-range address
    ras = {5'd19, 5'd9, 5'd25};
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 64'h99;
    #1;
    chk("s_oor_same", rd_s[63:0], 64'd0);
    step();
    wr_en = 1'b0;
    #1;
    chk("s_oor_after", rd_s[63:0], 64'd0);
    chk("s_r9_kept", rd_s[127:64], 64'hAA);
    chk("s_r19", rd_s[191:128], 64'd19);

    // Clear with a concurrent write
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55;
    step();
    wr_en = 1'b0; ra = {5'd0, 5'd3};
    #1;
    chk("wr_r3", rd[63:0], 64'h55);
    clear = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h77;
    step();
    clear = 1'b0; wr_en = 1'b0;
    #1;
    chk("clr_ready", 64'(ready), 64'd0);
    chk("clr_rd_init", rd[63:0], 64'd0);
    wait_ready(n, ns);
    chk("clr_len", 64'(n), 64'd32);
    ra = {5'd4, 5'd3};
    #1;
    chk("clr_r3", rd[63:0], 64'd3);
    chk("clr_r4", rd[127:64], 64'd4);

    // Reset mid-INIT, with writes during INIT
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("mid_init_ready", 64'(ready), 64'd0);
    step();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'hEE;
    repeat (5) step();
    wr_en = 1'b0;
    wait_ready(n, ns);
    chk("mid_init_len", 64'(n + 5), 64'd32);
    ra = {5'd0, 5'd2};
    #1;
    chk("mid_init_r2", rd[63:0], 64'd2);

    // Reset mid-RUN
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'hFF;
    step();
    wr_en = 1'b0;
    #1;
    chk("run_r2", rd[63:0], 64'hFF);
    rst = 1'b1;
    #1;
    chk("run_rst_ready", 64'(ready), 64'd0);
    chk("run_rst_rd", rd[63:0], 64'd0);
    step();
    rst = 1'b0;
    wait_ready(n, ns);
    chk("run_rst_len", 64'(n), 64'd32);
    #1;
    chk("run_rst_r2", rd[63:0], 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
